coord_framer: RTL and testbench

COORD_FRAMER -- requirements
Module: coord_framer

---
 rtl/coord_pkg.sv | 6 +
 rtl/border_cmp.sv | 19 +
 rtl/coord_framer.sv | 97 +++++++++
 tb/tb_coord_framer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/coord_pkg.sv
// coord_pkg: shared FSM encoding and frame counter width for coord_framer
package coord_pkg;
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;
    localparam int FCNT_W = 16;
endpackage

// File: rtl/border_cmp.sv
// border_cmp: flags a coordinate lying within BORDER pixels of any frame edge
module border_cmp #(
    parameter int COL_W  = 10,
    parameter int ROW_W  = 10,
    parameter int BORDER = 3
) (
    input  logic [COL_W-1:0] col,
    input  logic [COL_W-1:0] cols,
    input  logic [ROW_W-1:0] row,
    input  logic [ROW_W-1:0] rows,
    output logic             in_border
);
    localparam int CW = COL_W + 1;
    localparam int RW = ROW_W + 1;
    // x > cols-1-BORDER is rewritten as x+BORDER >= cols one bit wider, so narrow frames never underflow
    always_comb
        in_border = ({1'b0, col} < CW'(BORDER)) || ({1'b0, col} + CW'(BORDER) >= {1'b0, cols}) ||
                    ({1'b0, row} < RW'(BORDER)) || ({1'b0, row} + RW'(BORDER) >= {1'b0, rows});
endmodule

// File: rtl/coord_framer.sv
// coord_framer: tags a raster pixel stream with coordinates, frame markers and a border flag
module coord_framer import coord_pkg::*; #(
    parameter int PIX_W       = 8,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 10,
    parameter int BORDER      = 3,
    parameter int GAP_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COL_W-1:0]  cfg_cols,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [PIX_W-1:0]  din,
    input  logic              din_valid,
    output logic [PIX_W-1:0]  dout,
    output logic              dout_valid,
    output logic [COL_W-1:0]  col_cnt,
    output logic [ROW_W-1:0]  row_cnt,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              in_border,
    output logic              frame_err,
    output logic [FCNT_W-1:0] frame_cnt
);
    localparam int IW = $clog2(GAP_TIMEOUT + 1);
    logic [0:0]       state;
    logic [COL_W-1:0] lcols, ncol, pcol, dcols;
    logic [ROW_W-1:0] lrows, nrow, prow, drows;
    logic [IW-1:0]    idle_cnt;
    logic             start, accept, timeout, last_col, last_row, border;
    always_comb begin
        start    = state == S_IDLE && din_valid && cfg_cols != '0 && cfg_rows != '0;
        accept   = start || (state == S_ACTIVE && din_valid);
        timeout  = state == S_ACTIVE && !din_valid && idle_cnt == IW'(GAP_TIMEOUT - 1);
        dcols    = start ? cfg_cols : lcols;
        drows    = start ? cfg_rows : lrows;
        pcol     = start ? '0 : ncol;
        prow     = start ? '0 : nrow;
        last_col = pcol == dcols - COL_W'(1);
        last_row = prow == drows - ROW_W'(1);
    end
    border_cmp #(.COL_W(COL_W), .ROW_W(ROW_W), .BORDER(BORDER)) u_border (
        .col(pcol), .cols(dcols), .row(prow), .rows(drows), .in_border(border)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            lcols      <= '0;
            lrows      <= '0;
            ncol       <= '0;
            nrow       <= '0;
            idle_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            in_border  <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            dout_valid <= accept;
            sof        <= start;
            eol        <= accept && last_col;
            eof        <= accept && last_col && last_row;
            in_border  <= accept && border;
            frame_err  <= timeout;
            if (start) begin
                lcols <= cfg_cols;
                lrows <= cfg_rows;
            end
            if (accept) begin
                dout     <= din;
                col_cnt  <= pcol;
                row_cnt  <= prow;
                ncol     <= last_col ? '0 : pcol + COL_W'(1);
                nrow     <= last_col ? (last_row ? '0 : prow + ROW_W'(1)) : prow;
                idle_cnt <= '0;
                state    <= (last_col && last_row) ? S_IDLE : S_ACTIVE;
                if (last_col && last_row)
                    frame_cnt <= frame_cnt + FCNT_W'(1);
            end else if (timeout) begin
                col_cnt  <= '0;
                row_cnt  <= '0;
                ncol     <= '0;
                nrow     <= '0;
                idle_cnt <= '0;
                state    <= S_IDLE;
            end else if (state == S_ACTIVE) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_coord_framer.sv
// tb_coord_framer: scoreboard and table-driven checks of coord_framer with default parameters
module tb_coord_framer;
    logic        clk = 1'b0, rst = 1'b0;
    logic [9:0]  cfg_cols = '0, cfg_rows = '0;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic [7:0]  dout;
    logic        dout_valid, sof, eol, eof, in_border, frame_err;
    logic [9:0]  col_cnt, row_cnt;
    logic [15:0] frame_cnt;

    coord_framer dut (
        .clk(clk), .rst(rst), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .col_cnt(col_cnt), .row_cnt(row_cnt), .sof(sof), .eol(eol),
        .eof(eof), .in_border(in_border), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [9:0] c;
        logic [9:0] r;
        logic       sof;
        logic       eol;
        logic       eof;
        logic       brd;
    } px_t;

    typedef struct {
        int cols;
        int rows;
        int npix;
        int exp_valid;
        int exp_border;
        int exp_frames;
    } vec_t;

    px_t  q[$];
    int   checks = 0, failures = 0;
    int   err_pulses = 0, valid_seen = 0, border_seen = 0, b2b = 0;
    logic prev_eof = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit bexp(input int c, input int r, input int cols, input int rows);
        return c < 3 || c > cols - 4 || r < 3 || r > rows - 4;
    endfunction

    always @(negedge clk) begin : mon
        px_t e;
        if (frame_err) err_pulses++;
        if (dout_valid) begin
            valid_seen++;
            if (in_border) border_seen++;
            if (sof && prev_eof) b2b++;
            if (q.size() == 0) chk("unexpected_pixel", 64'(dout_valid), 64'd0);
            else begin
                e = q.pop_front();
                chk("pixel", 64'({dout, col_cnt, row_cnt, sof, eol, eof, in_border}), 64'(e));
            end
        end
        prev_eof = dout_valid && eof;
    end

    task automatic cyc(input logic v, input logic [7:0] d);
        din_valid = v;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00);
    endtask

    task automatic stream(input int cols, input int rows, input int first, input int n, input bit push);
        px_t e;
        logic [7:0] d;
        int c, r;
        for (int i = first; i < first + n; i++) begin
            d = 8'($urandom);
            if (push) begin
                c = i % cols;
                r = i / cols;
                e.d = d;
                e.c = 10'(c);
                e.r = 10'(r);
                e.sof = i == 0;
                e.eol = c == cols - 1;
                e.eof = i == cols * rows - 1;
                e.brd = bexp(c, r, cols, rows);
                q.push_back(e);
            end
            cyc(1'b1, d);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({dout, dout_valid, col_cnt, row_cnt, sof, eol, eof, in_border, frame_err, frame_cnt});
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int v0, b0, f0, e0;
        vt[0] = '{8, 6, 48, 48, 48, 1};
        vt[1] = '{10, 10, 100, 100, 84, 1};
        vt[2] = '{1, 1, 1, 1, 1, 1};
        vt[3] = '{5, 1, 5, 5, 5, 1};
        vt[4] = '{0, 4, 5, 0, 0, 0};
        vt[5] = '{3, 0, 5, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 64'd0);
        rst = 1'b1;

        cfg_cols = 10'd120;
        cfg_rows = 10'd100;
        stream(120, 100, 0, 12000, 1'b1);
        idle(1000);
        chk("f1_drained", 64'(q.size()), 64'd0);
        chk("f1_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("f1_no_err", 64'(err_pulses), 64'd0);

        b2b = 0;
        stream(120, 100, 0, 12000, 1'b1);
        stream(120, 100, 0, 12000, 1'b1);
        idle(3);
        chk("b2b_drained", 64'(q.size()), 64'd0);
        chk("b2b_sof_after_eof", 64'(b2b), 64'd1);
        chk("b2b_frame_cnt", 64'(frame_cnt), 64'd3);

        stream(120, 100, 0, 5000, 1'b1);
        idle(63);
        chk("gap63_no_err", 64'(frame_err), 64'd0);
        chk("gap63_err_count", 64'(err_pulses), 64'd0);
        idle(1);
        chk("timeout_err", 64'(frame_err), 64'd1);
        chk("timeout_coords", 64'({col_cnt, row_cnt}), 64'd0);
        stream(120, 100, 0, 1, 1'b1);
        idle(2);
        chk("timeout_sof_drained", 64'(q.size()), 64'd0);
        chk("timeout_err_once", 64'(err_pulses), 64'd1);
        chk("timeout_frame_cnt", 64'(frame_cnt), 64'd3);
        idle(64);
        chk("timeout2_err_count", 64'(err_pulses), 64'd2);

        cfg_cols = 10'd120;
        cfg_rows = 10'd100;
        stream(120, 100, 0, 6000, 1'b1);
        cfg_cols = 10'd64;
        cfg_rows = 10'd64;
        stream(120, 100, 6000, 6000, 1'b1);
        stream(64, 64, 0, 4096, 1'b1);
        idle(3);
        chk("cfgchg_drained", 64'(q.size()), 64'd0);
        chk("cfgchg_frame_cnt", 64'(frame_cnt), 64'd5);

        for (int k = 0; k < 6; k++) begin
            cfg_cols = 10'(vt[k].cols);
            cfg_rows = 10'(vt[k].rows);
            v0 = valid_seen;
            b0 = border_seen;
            f0 = int'(frame_cnt);
            stream(vt[k].cols, vt[k].rows, 0, vt[k].npix, vt[k].exp_valid != 0);
            idle(3);
            chk($sformatf("vec%0d_valid", k), 64'(valid_seen - v0), 64'(vt[k].exp_valid));
            chk($sformatf("vec%0d_border", k), 64'(border_seen - b0), 64'(vt[k].exp_border));
            chk($sformatf("vec%0d_frames", k), 64'(int'(frame_cnt) - f0), 64'(vt[k].exp_frames));
            chk($sformatf("vec%0d_drained", k), 64'(q.size()), 64'd0);
        end
        chk("no_spurious_err", 64'(err_pulses), 64'd2);

        cfg_cols = 10'd120;
        cfg_rows = 10'd100;
        stream(120, 100, 0, 3000, 1'b1);
        e0 = err_pulses;
        din = 8'h77;
        din_valid = 1'b1;
        #2 rst = 1'b0;
        #1 chk("async_reset", outs(), 64'd0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        stream(120, 100, 0, 120, 1'b1);
        idle(3);
        chk("rst_drained", 64'(q.size()), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_no_err", 64'(err_pulses), 64'(e0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
